// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: funct codes,
// 2-bit operation select and controller state encoding.
package muldiv_unit_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_ST_IDLE  = 2'b00,
        MD_ST_SETUP = 2'b01,
        MD_ST_RUN   = 2'b10,
        MD_ST_FIX   = 2'b11
    } md_state_e;

    function automatic logic md_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_negate.sv
// Conditional two's-complement negate; passes the value through when i_en is low.
module md_negate #(
    parameter int W = 32
) (
    input  logic         i_en,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_val
);

    assign o_val = i_en ? ((~i_val) + W'(1)) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one bit per cycle on
// operand magnitudes, sign fix-up applied in the final state.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [1:0]       i_mdop,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_hi_we,
    input  logic             i_lo_we,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = $clog2(WIDTH);

    md_state_e        r_state;
    md_op_e           r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [CW-1:0]    r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div0;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic               w_signed;
    logic               w_div;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_fits;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_signed = md_is_signed(r_op);
    assign w_div    = md_is_div(r_op);

    md_negate #(.W(WIDTH)) u_abs_a (
        .i_en  (w_signed & r_a[WIDTH-1]),
        .i_val (r_a),
        .o_val (w_mag_a)
    );

    md_negate #(.W(WIDTH)) u_abs_b (
        .i_en  (w_signed & r_b[WIDTH-1]),
        .i_val (r_b),
        .o_val (w_mag_b)
    );

    // Magnitudes are held as unsigned WIDTH-bit values, so |-2^(W-1)| is exact.
    assign w_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mag} : '0);
    assign w_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_mag};
    assign w_fits  = ~w_diff[WIDTH];

    md_negate #(.W(2*WIDTH)) u_fix_prod (
        .i_en  (r_neg_q),
        .i_val ({r_acc_hi, r_acc_lo}),
        .o_val (w_prod)
    );

    md_negate #(.W(WIDTH)) u_fix_quo (
        .i_en  (r_neg_q),
        .i_val (r_acc_lo),
        .o_val (w_quo)
    );

    md_negate #(.W(WIDTH)) u_fix_rem (
        .i_en  (r_neg_r),
        .i_val (r_acc_hi),
        .o_val (w_rem)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= MD_ST_IDLE;
            r_op     <= MD_MULT;
            r_a      <= '0;
            r_b      <= '0;
            r_mag    <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MD_ST_IDLE: begin
                    if (i_hi_we) r_hi <= i_a;
                    if (i_lo_we) r_lo <= i_a;
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_op    <= md_op_e'(i_mdop);
                        r_busy  <= 1'b1;
                        r_state <= MD_ST_SETUP;
                    end
                end
                MD_ST_SETUP: begin
                    r_mag    <= w_div ? w_mag_b : w_mag_a;
                    r_acc_hi <= '0;
                    r_acc_lo <= w_div ? w_mag_a : w_mag_b;
                    r_neg_q  <= w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_neg_r  <= w_signed & r_a[WIDTH-1];
                    r_div0   <= w_div & (r_b == '0);
                    r_cnt    <= '0;
                    r_state  <= MD_ST_RUN;
                end
                MD_ST_RUN: begin
                    if (w_div) begin
                        r_acc_hi <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                        r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_fits};
                    end else begin
                        r_acc_hi <= w_sum[WIDTH:1];
                        r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
                    end
                    if (r_cnt == CW'(WIDTH-1)) begin
                        r_state <= MD_ST_FIX;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                MD_ST_FIX: begin
                    // Divide by zero returns the dividend in HI and all-ones in LO.
                    if (r_div0) begin
                        r_hi <= r_a;
                        r_lo <= '1;
                    end else if (w_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= MD_ST_IDLE;
                end
                default: r_state <= MD_ST_IDLE;
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, protocol checks
// and randomized operations against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        hi_we;
    logic        lo_we;
    logic [1:0]  mdop;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_hilo;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .i_start (start),
        .i_mdop  (mdop),
        .i_a     (a),
        .i_b     (b),
        .i_hi_we (hi_we),
        .i_lo_we (lo_we),
        .o_busy  (busy),
        .o_done  (done),
        .o_hi    (hi),
        .o_lo    (lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: {HI, LO} straight from signed/unsigned *, / and %.
    function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] x,
                                           input logic [31:0] y);
        longint sx, sy, q, r, p;
        logic [63:0] u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (op)
            2'b00: begin
                p = sx * sy;
                return p;
            end
            2'b01: begin
                u = {32'b0, x} * {32'b0, y};
                return u;
            end
            2'b10: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Called at #1 after an edge; the op is captured on the next edge (edge 0).
    task automatic launch(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1;
        mdop  = op;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after edge 0 (starting from base) until Done is seen; -1 on timeout.
    task automatic wait_done(input int base, output int cyc, output bit busy_ok);
        bit found;
        found   = 1'b0;
        busy_ok = 1'b1;
        cyc     = base;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                found = 1'b1;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        if (!found) cyc = -1;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] av,
                          input logic [31:0] bv);
        int cyc;
        bit bok;
        launch(op, av, bv);
        wait_done(0, cyc, bok);
        exp_hilo = ref_md(op, av, bv);
        chk({tag, " latency"}, 64'(cyc), 64'd34);
        chk({tag, " hilo"}, {hi, lo}, exp_hilo);
    endtask

    initial begin
        int cyc;
        bit bok;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        rst   = 1'b1;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        mdop  = 2'b00;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy/done", {62'b0, busy, done}, 64'd0);
        chk("reset hilo", {hi, lo}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        hi_we = 1'b1;
        a     = 32'h1111_2222;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        chk("idle hiwe", {32'b0, hi}, {32'b0, 32'h1111_2222});

        // MULTU with full latency/Busy/Done shape
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("busy after edge0", {63'b0, busy}, 64'd1);
        wait_done(0, cyc, bok);
        chk("multu done cycle", 64'(cyc), 64'd34);
        chk("multu busy window", {63'b0, bok}, 64'd1);
        chk("multu hilo", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});
        @(posedge clk);
        #1;
        chk("done one-cycle", {63'b0, done}, 64'd0);

        run_op("mult -2*3", 2'b00, 32'hFFFF_FFFE, 32'h0000_0003);
        chk("mult -2*3 const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
        run_op("mult min*min", 2'b00, 32'h8000_0000, 32'h8000_0000);
        chk("mult min*min const", {hi, lo}, {32'h4000_0000, 32'h0});
        run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        chk("div -7/2 const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("divu -7/2", 2'b11, 32'hFFFF_FFF9, 32'd2);
        chk("divu -7/2 const", {hi, lo}, {32'h0000_0001, 32'h7FFF_FFFC});
        run_op("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div min/-1 const", {hi, lo}, {32'h0, 32'h8000_0000});
        run_op("divu by0", 2'b11, 32'h0000_1234, 32'h0);
        chk("divu by0 const", {hi, lo}, {32'h0000_1234, 32'hFFFF_FFFF});
        run_op("div by0", 2'b10, 32'h8765_4321, 32'h0);

        // Start and HiWe while busy must both be ignored
        launch(2'b11, 32'd100, 32'd7);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        mdop  = 2'b01;
        a     = 32'd5;
        b     = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b1;
        a     = 32'h0000_DEAD;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        chk("hiwe while busy", {hi, lo}, exp_hilo);
        wait_done(11, cyc, bok);
        chk("divu 100/7 latency", 64'(cyc), 64'd34);
        chk("divu 100/7 hilo", {hi, lo}, {32'd2, 32'd14});

        // Back-to-back: second launch lands in the Done cycle
        run_op("b2b first", 2'b00, 32'hFFFF_FF00, 32'h0000_0100);
        run_op("b2b second", 2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFFD);

        // Asynchronous reset in the middle of a DIV
        launch(2'b10, 32'hFFFF_FF9C, 32'd7);
        repeat (11) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midop rst busy/done", {62'b0, busy, done}, 64'd0);
        chk("midop rst hilo", {hi, lo}, 64'd0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        lo_we = 1'b1;
        a     = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        lo_we = 1'b0;
        chk("lowe after rst", {hi, lo}, {32'h0, 32'hCAFE_F00D});
        run_op("multu 3*4", 2'b01, 32'd3, 32'd4);
        chk("multu 3*4 const", {hi, lo}, {32'h0, 32'd12});

        for (int n = 0; n < 200; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 9))
                0:       rb = 32'($urandom_range(0, 2));
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 255));
                default: rb = 32'($urandom);
            endcase
            run_op($sformatf("rand%0d op%0d", n, rop), rop, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle integer multiply/divide unit for the MIPS150 execute stage; owns the HI/LO registers. It sits beside the combinational ALU.
- Executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle, and services MTHI/MTLO writes.
- Control issues an operation with a Start pulse, stalls on Busy, and reads HI/LO through MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  issue request; sampled only when the unit is idle.
- MDop  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU (equals funct[1:0]).
- A  input  WIDTH  rs operand (dividend or multiplicand); also the MTHI/MTLO data.
- B  input  WIDTH  rt operand (divisor or multiplier).
- HiWe  input  1  MTHI write strobe.
- LoWe  input  1  MTLO write strobe.
- Busy  output  1  high whenever the state is not IDLE.
- Done  output  1  one-cycle pulse: HI/LO updated by a completed operation.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state = IDLE; HI = 0, LO = 0, Done = 0, Busy = 0; iteration counter = 0.
  - No partial result is ever written.
- States:
  - IDLE -> SETUP on Start = 1. A, B and MDop are latched on this edge.
  - SETUP -> RUN. Absolute values are taken for signed ops; result signs are recorded; counter = 0.
  - RUN iterates for 32 cycles, then -> FIX at the edge where counter = WIDTH-1.
  - FIX -> IDLE. Sign correction is applied, HI/LO are written and Done = 1 on this edge.
- Timing:
  - Start is captured at edge 0; HI/LO are valid and Done is high after edge 34. Latency is 34 cycles.
  - Busy is high from after edge 0 until edge 34.
- Multiply:
  - Shift-add on magnitudes into a 64-bit product.
  - For MULT, the 64-bit product is negated when sign(A) != sign(B).
  - HI = product[63:32], LO = product[31:0].
- Divide:
  - Restoring division on magnitudes.
  - LO = quotient, truncated toward zero.
  - HI = remainder, carrying the sign of the dividend (DIV only).
- Divide by zero (DIV and DIVU): HI = A and LO = 0xFFFFFFFF after the normal 34-cycle latency. No exception is raised.
- DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0. The magnitude path must be 33-bit safe.
- Start while Busy: ignored. Latched operands are unaffected.
- Start in the same cycle Done is high: accepted, because the state is already IDLE.
- HiWe/LoWe:
  - When IDLE, HI or LO is written with A on the edge.
  - When Busy, the write is dropped; control guarantees a stall instead.
  - HiWe/LoWe together with Start in IDLE: the write occurs, then the operation overwrites HI/LO at completion.
- Done is registered and is deasserted in every cycle except the one following FIX.
- MDop values outside the four listed do not exist (2-bit field; all encodings are defined).

Decomposition:
- Opcode.v gains these defines:
  - funct codes MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
  - MD_MULT/MD_MULTU/MD_DIV/MD_DIVU 2-bit encodings.
  - MD_ST_IDLE/SETUP/RUN/FIX state encodings.
- One sub-module, md_negate: combinational conditional two's-complement negate.
  - Parameterised width.
  - Used for operand absolute values (WIDTH) and for result correction (2*WIDTH).

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Done is high exactly at cycle 34 for one cycle; Busy is high during cycles 1-34.
- MULT A=0xFFFFFFFE (-2), B=0x00000003 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU with the same operands -> LO=0x7FFFFFFC, HI=0x00000001.
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU A=0x00001234, B=0 -> HI=0x00001234, LO=0xFFFFFFFF after 34 cycles.
- Protocol checks:
  - Start DIVU 100/7 -> HI=2, LO=14.
  - A Start of MULTU 5x5 at cycle 10 is ignored; the first result is intact.
  - HiWe with A=0xDEAD while Busy -> HI unchanged.
  - Back-to-back Start in the Done cycle -> second result after a further 34 cycles.
- Reset asserted at cycle 12 of a DIV -> Busy, Done, HI and LO all 0 immediately, with no clock edge required.
  - After release, LoWe with A=0xCAFEF00D -> LO=0xCAFEF00D.
  - A subsequent MULTU 3x4 -> LO=12, HI=0.
- Randomised: 200 operations, each checked against $signed/unsigned * and / and % reference results, Start pulsed every 35 cycles.
